// File: rtl/pipe_mux_n.sv
// N-input, WIDTH-bit registered selector with a valid/ready handshake and a 2-entry skid buffer.
// Define PIPE_MUX_BYPASS_EN for a 0-cycle pass-through whenever both entries are empty.
module pipe_mux_n #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  input  logic                    err_clr
);

  logic             main_v;
  logic             skid_v;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_d;
  logic [WIDTH-1:0] sel_val;
  logic             sel_oor;
  logic             accept;
  logic             pop;

  // Out-of-range selects produce zero rather than aliasing onto another input.
  always_comb begin
    sel_val = '0;
    sel_oor = (32'(sel) >= NUM_IN);
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_val = in_bus[k*WIDTH +: WIDTH];
      end
    end
  end

  assign in_ready = ~skid_v;
  assign accept   = in_valid & in_ready;

`ifdef PIPE_MUX_BYPASS_EN
  logic bypass_act;
  assign bypass_act = ~main_v & ~skid_v;
  assign out_valid  = bypass_act ? in_valid : main_v;
  assign out_data   = bypass_act ? sel_val : main_d;
`else
  assign out_valid  = main_v;
  assign out_data   = main_d;
`endif

  assign pop = out_valid & out_ready;

  // In bypass mode a popped accept from the empty state completes immediately and stores nothing.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= '0;
      skid_d <= '0;
    end else if (!main_v) begin
      if (accept && !pop) begin
        main_v <= 1'b1;
        main_d <= sel_val;
      end
    end else if (!skid_v) begin
      if (accept && pop) begin
        main_d <= sel_val;
      end else if (accept) begin
        skid_v <= 1'b1;
        skid_d <= sel_val;
      end else if (pop) begin
        main_v <= 1'b0;
      end
    end else if (pop) begin
      main_d <= skid_d;
      skid_v <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_err <= 1'b0;
    end else if (accept && sel_oor) begin
      sel_err <= 1'b1;
    end else if (err_clr) begin
      sel_err <= 1'b0;
    end
  end

endmodule
